// File: rtl/npu_fc_argmax_stage_if.sv
// Handshake and FIFO-side bundle for npu_fc_argmax_stage.
// The master drives beats and pops; the slave is the stage itself.
interface npu_fc_argmax_stage_if #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = $clog2(LANES)
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_last;
   logic [DATA_W-1:0]         in_x;
   logic [LANES*DATA_W-1:0]   in_w;
   logic                      rd_en;
   logic [IDX_W+DATA_W-1:0]   data_out;
   logic                      full;
   logic                      empty;
   logic                      busy;

   modport master (
      output in_valid, in_last, in_x, in_w, rd_en,
      input  in_ready, data_out, full, empty, busy
   );

   modport slave (
      input  in_valid, in_last, in_x, in_w, rd_en,
      output in_ready, data_out, full, empty, busy
   );
endinterface

// File: rtl/npu_fc_argmax_stage.sv
// FC output stage: LANES MAC accumulators, ReLU, sequential argmax, show-ahead record FIFO.
// Define NPU_FC_ACC_SAT_EN for saturating accumulators; otherwise they wrap two's complement.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_ACC  | accept beats, accumulate x*w into every lane
// ST_SCAN | compare one lane per cycle against the running best
// ST_PUSH | write {best_idx, clipped best} once the FIFO has room
module npu_fc_argmax_stage #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = $clog2(LANES)
) (
   input logic                  clkext,
   input logic                  rst,
   npu_fc_argmax_stage_if.slave bus
);

   localparam int PROD_W = 2*DATA_W + 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int REC_W  = IDX_W + DATA_W;
   localparam logic [ACC_W-1:0] CLIP_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   typedef enum logic [1:0] {ST_ACC, ST_SCAN, ST_PUSH} state_t;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc     [LANES];
   logic signed [ACC_W-1:0] acc_upd [LANES];
   logic signed [PROD_W-1:0] prod   [LANES];
   logic [IDX_W-1:0]        scan_idx;
   logic                    scan_last;
   logic [ACC_W-1:0]        best;
   logic [IDX_W-1:0]        best_idx;
   logic [ACC_W-1:0]        relu_val;
   logic [DATA_W-1:0]       rec_val;
   logic                    beat_acc, scan_en, push_en, push_ok;

   logic [REC_W-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [PTR_W:0]          count, cnt_nxt;
   logic                    full_q, empty_q, do_rd;

   assign scan_last = (scan_idx == IDX_W'(LANES-1));
   assign do_rd     = bus.rd_en && !empty_q;
   // A pop on the same edge frees the slot the pending record needs.
   assign push_ok   = !full_q || do_rd;
   assign beat_acc  = bus.in_valid && bus.in_ready;

   always_ff @(posedge clkext or posedge rst) begin
      if (rst) state <= ST_ACC;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACC:  if (beat_acc && bus.in_last) state_nxt = ST_SCAN;
         ST_SCAN: if (scan_last)               state_nxt = ST_PUSH;
         ST_PUSH: if (push_ok)                 state_nxt = ST_ACC;
         default:                              state_nxt = ST_ACC;
      endcase
   end

   always_comb begin
      bus.in_ready = 1'b0;
      bus.busy     = 1'b1;
      scan_en      = 1'b0;
      push_en      = 1'b0;
      case (state)
         ST_ACC: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         ST_SCAN: scan_en = 1'b1;
         ST_PUSH: push_en = push_ok;
         default: ;
      endcase
   end

`ifdef NPU_FC_ACC_SAT_EN
   localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
   localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   logic signed [SUM_W-1:0] sum [LANES];
`endif

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod[i] = PROD_W'(signed'({1'b0, bus.in_x})) *
                   PROD_W'(signed'(bus.in_w[i*DATA_W +: DATA_W]));
`ifdef NPU_FC_ACC_SAT_EN
         sum[i] = SUM_W'(acc[i]) + SUM_W'(prod[i]);
         if (sum[i] > ACC_MAX)      acc_upd[i] = {1'b0, {(ACC_W-1){1'b1}}};
         else if (sum[i] < ACC_MIN) acc_upd[i] = {1'b1, {(ACC_W-1){1'b0}}};
         else                       acc_upd[i] = sum[i][ACC_W-1:0];
`else
         acc_upd[i] = acc[i] + ACC_W'(prod[i]);
`endif
      end
   end

   always_ff @(posedge clkext or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (push_en) begin
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (beat_acc) begin
         for (int i = 0; i < LANES; i++) acc[i] <= acc_upd[i];
      end
   end

   assign relu_val = acc[scan_idx][ACC_W-1] ? '0 : acc[scan_idx];

   // Strict compare keeps the lowest index on ties.
   always_ff @(posedge clkext or posedge rst) begin
      if (rst) begin
         scan_idx <= '0;
         best     <= '0;
         best_idx <= '0;
      end else if (scan_en) begin
         if (scan_idx == '0 || relu_val > best) begin
            best     <= relu_val;
            best_idx <= scan_idx;
         end
         scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
      end
   end

   assign rec_val = (best > CLIP_MAX) ? '1 : best[DATA_W-1:0];

   always_comb begin
      cnt_nxt = count;
      if (push_en && !do_rd)      cnt_nxt = count + 1'b1;
      else if (!push_en && do_rd) cnt_nxt = count - 1'b1;
   end

   always_ff @(posedge clkext or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)   rd_ptr <= rd_ptr + 1'b1;
         count   <= cnt_nxt;
         full_q  <= (cnt_nxt == (PTR_W+1)'(DEPTH));
         empty_q <= (cnt_nxt == '0);
      end
   end

   always_ff @(posedge clkext) begin
      if (push_en) mem[wr_ptr] <= {best_idx, rec_val};
   end

   assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;

endmodule

// File: tb/tb_npu_fc_argmax_stage.sv
// Bench for npu_fc_argmax_stage: directed samples, transaction model, per-cycle compare.
module tb_npu_fc_argmax_stage;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 20;
   localparam int DEPTH  = 8;
`ifdef NPU_FC_ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   npu_fc_argmax_stage_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();
   npu_fc_argmax_stage_if #(.LANES(LANES), .DATA_W(DATA_W)) bus16 ();

   npu_fc_argmax_stage #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
      .clkext(clk), .rst(rst), .bus(bus));

   npu_fc_argmax_stage #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(16), .DEPTH(DEPTH)) dut16 (
      .clkext(clk), .rst(rst), .bus(bus16));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint fix_acc(input longint v, input int accw, input bit sat);
      longint hi, lo, m;
      hi = (64'sd1 <<< (accw-1)) - 1;
      lo = -(64'sd1 <<< (accw-1));
      m  = 64'sd1 <<< accw;
      if (sat) return (v > hi) ? hi : (v < lo) ? lo : v;
      v = v & (m - 1);
      if (v > hi) v = v - m;
      return v;
   endfunction

   function automatic int make_rec(input longint a[LANES]);
      longint best, r;
      int idx;
      best = -1;
      idx  = 0;
      for (int i = 0; i < LANES; i++) begin
         r = (a[i] < 0) ? 0 : a[i];
         if (r > best) begin best = r; idx = i; end
      end
      if (best > 255) best = 255;
      return (idx << DATA_W) | int'(best);
   endfunction

   function automatic logic [31:0] pack_w(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // Transaction model: records queue, one pending sample with its scan delay.
   int     mq[$];
   bit     pend;
   int     pend_cnt;
   int     pend_rec;
   longint macc[LANES];
   bit     m_pop, m_push;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         pend     = 1'b0;
         pend_cnt = 0;
         for (int i = 0; i < LANES; i++) macc[i] = 0;
      end else begin
         m_pop  = bus.rd_en && (mq.size() > 0);
         m_push = 1'b0;
         if (pend) begin
            if (pend_cnt > 0) pend_cnt--;
            else if (mq.size() < DEPTH || m_pop) begin
               m_push = 1'b1;
               pend   = 1'b0;
            end
         end else if (bus.in_valid) begin
            for (int i = 0; i < LANES; i++)
               macc[i] = fix_acc(macc[i] + longint'(bus.in_x) *
                                 longint'($signed(bus.in_w[i*DATA_W +: DATA_W])), ACC_W, SAT);
            if (bus.in_last) begin
               pend_rec = make_rec(macc);
               pend     = 1'b1;
               pend_cnt = LANES;
               for (int i = 0; i < LANES; i++) macc[i] = 0;
            end
         end
         if (m_pop)  void'(mq.pop_front());
         if (m_push) mq.push_back(pend_rec);
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("cyc_empty", longint'(bus.empty), longint'(mq.size() == 0));
         check("cyc_full", longint'(bus.full), longint'(mq.size() == DEPTH));
         check("cyc_data", longint'(bus.data_out), (mq.size() > 0) ? longint'(mq[0]) : 0);
         check("cyc_ready", longint'(bus.in_ready), longint'(!pend));
         check("cyc_busy", longint'(bus.busy), longint'(pend));
      end
   end

   task automatic send_beat(input int x, input logic [31:0] w, input bit last);
      int n = 0;
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
      end
      bus.in_valid = 1'b1;
      bus.in_x     = 8'(x);
      bus.in_w     = w;
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: busy stayed 1, expected 0 within 100 cycles");
      end
   endtask

   task automatic pop_one();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   function automatic int bp_rec(input int k);
      return ((k % 4) << DATA_W) | (k + 1);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
      $fatal(1);
   end

   initial begin
      longint a16[LANES];
      bus.in_valid = 0; bus.in_last = 0; bus.in_x = 0; bus.in_w = 0; bus.rd_en = 0;
      bus16.in_valid = 0; bus16.in_last = 0; bus16.in_x = 0; bus16.in_w = 0; bus16.rd_en = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      check("rst_ready", longint'(bus.in_ready), 1);
      check("rst_data", longint'(bus.data_out), 0);
      check("rst_full", longint'(bus.full), 0);
      check("rst_empty", longint'(bus.empty), 1);
      check("rst_busy", longint'(bus.busy), 0);

      // 16-bit accumulator instance: saturate vs wrap
      bus16.in_valid = 1'b1; bus16.in_x = 8'd255; bus16.in_w = pack_w(127, 1, 0, 0);
      @(negedge clk);
      bus16.in_last = 1'b1;
      @(negedge clk);
      bus16.in_valid = 1'b0; bus16.in_last = 1'b0;
      repeat (LANES + 2) @(negedge clk);
      a16[0] = fix_acc(fix_acc(255*127, 16, SAT) + 255*127, 16, SAT);
      a16[1] = 510; a16[2] = 0; a16[3] = 0;
      check("acc16_model", longint'(bus16.data_out), longint'(make_rec(a16)));
      check("acc16_lit", longint'(bus16.data_out), SAT ? 64'h0FF : 64'h1FF);
      check("acc16_empty", longint'(bus16.empty), 0);

      // single beat, latency pinned
      send_beat(10, pack_w(1, 2, 3, 4), 1'b1);
      repeat (LANES) @(negedge clk);
      check("a_pre_empty", longint'(bus.empty), 1);
      check("a_pre_ready", longint'(bus.in_ready), 0);
      @(negedge clk);
      check("a_data", longint'(bus.data_out), 64'h328);
      check("a_empty", longint'(bus.empty), 0);
      check("a_ready", longint'(bus.in_ready), 1);
      pop_one();
      check("a_pop_empty", longint'(bus.empty), 1);
      check("a_pop_data", longint'(bus.data_out), 0);

      // tie and ReLU
      send_beat(5, pack_w(2, 2, -1, 0), 1'b1);
      send_beat(3, pack_w(-1, -2, -3, -4), 1'b1);
      wait_idle();
      check("tie_rec", longint'(bus.data_out), 64'h00A);
      pop_one();
      check("relu_rec", longint'(bus.data_out), 64'h000);
      check("relu_nonempty", longint'(bus.empty), 0);
      pop_one();
      check("relu_pop_empty", longint'(bus.empty), 1);

      // output clip
      send_beat(255, pack_w(0, 1, 0, 0), 1'b0);
      send_beat(255, pack_w(0, 1, 0, 0), 1'b1);
      wait_idle();
      check("clip_rec", longint'(bus.data_out), 64'h1FF);
      pop_one();

      // back-pressure
      for (int k = 0; k < 8; k++) send_beat(k + 1, 32'(1) << (8 * (k % 4)), 1'b1);
      wait_idle();
      check("bp_full8", longint'(bus.full), 1);
      check("bp_head0", longint'(bus.data_out), 64'h001);
      send_beat(9, 32'(1), 1'b1);
      repeat (LANES + 3) @(negedge clk);
      check("bp_hold_ready", longint'(bus.in_ready), 0);
      check("bp_hold_busy", longint'(bus.busy), 1);
      check("bp_hold_full", longint'(bus.full), 1);
      pop_one();
      check("bp_still_full", longint'(bus.full), 1);
      check("bp_ready_back", longint'(bus.in_ready), 1);
      for (int k = 1; k < 9; k++) begin
         check("bp_order", longint'(bus.data_out), longint'(bp_rec(k)));
         pop_one();
      end
      check("bp_drained", longint'(bus.empty), 1);

      // reset during SCAN with records queued
      for (int k = 0; k < 3; k++) send_beat(k + 2, pack_w(1, 0, 0, 0), 1'b1);
      wait_idle();
      send_beat(4, pack_w(0, 0, 0, 1), 1'b1);
      @(negedge clk);
      check("mid_scan_busy", longint'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_empty", longint'(bus.empty), 1);
      check("rst_mid_ready", longint'(bus.in_ready), 1);
      check("rst_mid_busy", longint'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      send_beat(1, pack_w(0, 0, 7, 0), 1'b1);
      wait_idle();
      check("post_rst_rec", longint'(bus.data_out), 64'h207);
      pop_one();
      check("post_rst_empty", longint'(bus.empty), 1);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/npu_fc_argmax_stage.md
# npu_fc_argmax_stage

Parametrised fully-connected output stage for the NPU classifier datapath. It streams one unsigned activation per beat against LANES signed weights, accumulates LANES dot products, applies ReLU, and finds the winning lane with a sequential argmax scan. It then pushes an {index, clipped value} record into an internal show-ahead output FIFO that the host drains with RD_EN. It generalises the fixed 4-lane MAC/ReLU/comparator/FIFO path to arbitrary lane count, widths and FIFO depth, and adds a valid/ready input handshake plus back-pressure.

## Interface
- LANES, 4: output neurons / accumulators, ≥2
- DATA_W, 8: activation and weight width
- ACC_W, 20: signed accumulator width, ≥2*DATA_W+1
- DEPTH, 8: output FIFO entries, power of two ≥2
- IDX_W, $clog2(LANES): index field width
- CLKEXT  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  beat valid
- IN_READY  out  1  stage accepts a beat
- IN_LAST  in  1  final beat of a sample
- IN_X  in  DATA_W  unsigned activation, shared by all lanes
- IN_W  in  LANES*DATA_W  signed weights; lane i at [i*DATA_W +: DATA_W]
- RD_EN  in  1  pop FIFO head
- DATA_OUT  out  IDX_W+DATA_W  FIFO head {index, value}; 0 when EMPTY
- FULL  out  1  FIFO holds DEPTH records
- EMPTY  out  1  FIFO holds 0 records
- BUSY  out  1  state ≠ ACC

## Operation
- States: ACC, SCAN, PUSH.
- ACC: IN_READY=1. A beat is accepted when IN_VALID&&IN_READY: acc[i] += zero-extended IN_X × sign-extended IN_W lane i, with a signed product of 2*DATA_W+1 bits. With IN_LAST it goes to SCAN, else it stays in ACC.
- SCAN: one lane per cycle, lane 0 first. r[i]=max(acc[i],0) (ReLU). The best register loads r[i] if i==0 or r[i]>best (strict). Ties therefore go to the lowest index. After lane LANES-1 the state goes to PUSH.
- PUSH: if !FULL, write {best_idx, min(best, 2^DATA_W-1)}, clear all accumulators, go to ACC. If FULL, hold in PUSH (IN_READY=0) until a pop frees space.
- FIFO: show-ahead. RD_EN with EMPTY is ignored. Write with FULL never occurs. Simultaneous write and read in PUSH when FULL: the read frees the slot and the write completes on the same edge. Simultaneous write and read otherwise both occur and the count is unchanged. Pointers wrap modulo DEPTH.
- Reset (any time, including mid-SCAN/PUSH): state ACC, accumulators, best, pointers and count cleared. In-flight sample and FIFO contents are discarded.

## Timing
- Reset values: IN_READY=1, DATA_OUT=0, FULL=0, EMPTY=1, BUSY=0.
- Last beat accepted at edge E0. Lane i is compared at edge E(i+1). The record is written at edge E(LANES+1) if not FULL. EMPTY falls and DATA_OUT is valid right after that edge. IN_READY rises after that edge.
- Minimum sample overhead: LANES+1 cycles with IN_READY=0 after the last beat.
- Pop: DATA_OUT/FULL/EMPTY update on the edge where RD_EN is sampled.
- FULL/EMPTY are registered, derived from the count.

## Configuration
- NPU_FC_ACC_SAT_EN defined: each accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- NPU_FC_ACC_SAT_EN undefined: accumulators wrap modulo 2^ACC_W (two's complement).

## Test plan
- One beat, x=10, w=(1,2,3,4), IN_LAST=1 → after 5 cycles DATA_OUT={2'd3,8'd40}=10'h328, EMPTY=0. RD_EN → EMPTY=1, DATA_OUT=0.
- Tie and ReLU: x=5, w=(2,2,-1,0) → {0,10}. Then x=3, w=(-1,-2,-3,-4) → {0,0}.
- Output clip: two beats x=255, w=(0,1,0,0) → acc1=510 → {1,255}.
- Back-pressure: 9 samples with no RD_EN → FULL after the 8th. The 9th holds in PUSH with IN_READY=0. A single RD_EN pulse lets the 9th record write on the same edge and FULL stays 1. All 9 are then read in order.
- Macro, ACC_W=16: two beats x=255, w=(127,1,0,0). With NPU_FC_ACC_SAT_EN → {0,255}. Without it, acc0 wraps to -766 → {1,255}.
- Reset asserted mid-SCAN with 3 records queued → EMPTY=1, IN_READY=1, BUSY=0 immediately. The next sample x=1, w=(0,0,7,0) → {2,7}.
